// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock: timer states, BCD digits,
// the packed mm:ss value and helpers used for parameter checks and reload values.
package chess_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_t;

    typedef enum logic {
        OP_DEC = 1'b0,
        OP_INC = 1'b1
    } arith_op_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t min_tens;
        bcd_digit_t min_ones;
        bcd_digit_t sec_tens;
        bcd_digit_t sec_ones;
    } mmss_t;

    localparam int MAX_MIN = 99;
    localparam int MAX_SEC = 59;

    function automatic bit in_range(input int value, input int hi);
        return (value >= 0) && (value <= hi);
    endfunction

    function automatic mmss_t to_mmss(input int mins, input int secs);
        mmss_t t;
        t.min_tens = 4'(mins / 10);
        t.min_ones = 4'(mins % 10);
        t.sec_tens = 4'(secs / 10);
        t.sec_ones = 4'(secs % 10);
        return t;
    endfunction

endpackage

// File: rtl/player_timer_if.sv
// Control inputs and BCD/status outputs of one player's countdown timer.
interface player_timer_if;
    import chess_clock_pkg::*;

    logic       TICK;
    logic       ENABLE;
    logic       LOAD;
    bcd_digit_t MIN_TENS;
    bcd_digit_t MIN_ONES;
    bcd_digit_t SEC_TENS;
    bcd_digit_t SEC_ONES;
    logic       TIMEOUT;
    logic       RUNNING;

    modport master (
        output TICK, ENABLE, LOAD,
        input  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, TIMEOUT, RUNNING
    );

    modport slave (
        input  TICK, ENABLE, LOAD,
        output MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, TIMEOUT, RUNNING
    );
endinterface

// File: rtl/bcd_mmss_arith.sv
// Combinational mm:ss BCD arithmetic: decrement by one second (stopping at 00:00)
// or add INC_SEC seconds with carry; overflow past 99 minutes is flagged, not clamped.
module bcd_mmss_arith
    import chess_clock_pkg::*;
#(
    parameter int INC_SEC = 0
) (
    input  mmss_t     cur,
    input  arith_op_t op,
    output mmss_t     result,
    output logic      zero,
    output logic      sat
);

    localparam logic [6:0] INC7 = 7'(INC_SEC);

    mmss_t      dec_time;
    mmss_t      inc_time;
    logic [6:0] sec_bin;
    logic [6:0] sec_sum;
    logic [6:0] sec_wrap;
    logic       sec_carry;
    logic [6:0] min_bin;
    logic [7:0] min_sum;

    always_comb begin
        dec_time = cur;
        if (cur != '0) begin
            if (cur.sec_ones != 4'd0) begin
                dec_time.sec_ones = cur.sec_ones - 4'd1;
            end else begin
                dec_time.sec_ones = 4'd9;
                if (cur.sec_tens != 4'd0) begin
                    dec_time.sec_tens = cur.sec_tens - 4'd1;
                end else begin
                    dec_time.sec_tens = 4'd5;
                    if (cur.min_ones != 4'd0) begin
                        dec_time.min_ones = cur.min_ones - 4'd1;
                    end else begin
                        dec_time.min_ones = 4'd9;
                        dec_time.min_tens = cur.min_tens - 4'd1;
                    end
                end
            end
        end
    end

    // Increment goes through binary; the operands are tiny so the dividers stay small.
    always_comb begin
        sec_bin   = 7'(cur.sec_tens) * 7'd10 + 7'(cur.sec_ones);
        sec_sum   = sec_bin + INC7;
        sec_carry = (sec_sum >= 7'd60);
        sec_wrap  = sec_carry ? (sec_sum - 7'd60) : sec_sum;
        min_bin   = 7'(cur.min_tens) * 7'd10 + 7'(cur.min_ones);
        min_sum   = {1'b0, min_bin} + {7'd0, sec_carry};
        inc_time.sec_tens = 4'(sec_wrap / 7'd10);
        inc_time.sec_ones = 4'(sec_wrap % 7'd10);
        inc_time.min_tens = 4'(min_sum / 8'd10);
        inc_time.min_ones = 4'(min_sum % 8'd10);
    end

    assign result = (op == OP_INC) ? inc_time : dec_time;
    assign zero   = (op == OP_DEC) && (dec_time == '0);
    assign sat    = (op == OP_INC) && (min_sum > 8'd99);

endmodule

// File: rtl/player_timer.sv
// One player's countdown: BCD mm:ss decremented on TICK while enabled, Fischer
// increment when the turn ends, and a sticky TIMEOUT once 00:00 is reached.
module player_timer
    import chess_clock_pkg::*;
#(
    parameter int INIT_MIN = 5,
    parameter int INIT_SEC = 0,
    parameter int INC_SEC  = 0
) (
    input  logic           CLK,
    input  logic           CLR,
    player_timer_if.slave  tmr
);

    if (!in_range(INIT_MIN, MAX_MIN)) begin : g_bad_init_min
        $error("player_timer: INIT_MIN must be 0..99");
    end
    if (!in_range(INIT_SEC, MAX_SEC)) begin : g_bad_init_sec
        $error("player_timer: INIT_SEC must be 0..59");
    end
    if (!in_range(INC_SEC, MAX_SEC)) begin : g_bad_inc_sec
        $error("player_timer: INC_SEC must be 0..59");
    end

    localparam mmss_t INIT_TIME = to_mmss(INIT_MIN, INIT_SEC);
    localparam mmss_t MAX_TIME  = to_mmss(MAX_MIN, MAX_SEC);

    timer_state_t state_reg, state_next;
    mmss_t        time_reg, time_next;
    logic         en_q_reg;
    logic         running_reg;
    logic         timeout_reg;

    logic         fall;
    logic         cur_zero;
    arith_op_t    arith_op;
    mmss_t        arith_res;
    logic         arith_zero;
    logic         arith_sat;

    assign fall     = en_q_reg & ~tmr.ENABLE;
    assign cur_zero = (time_reg == '0);
    assign arith_op = fall ? OP_INC : OP_DEC;

    bcd_mmss_arith #(
        .INC_SEC (INC_SEC)
    ) u_arith (
        .cur    (time_reg),
        .op     (arith_op),
        .result (arith_res),
        .zero   (arith_zero),
        .sat    (arith_sat)
    );

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tmr.ENABLE) begin
                    if (tmr.TICK) begin
                        time_next = arith_res;
                    end
                    // A starting value of 00:00 still spends one cycle in RUN.
                    state_next = (tmr.TICK && arith_zero && !cur_zero) ? ST_EXPIRED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!tmr.ENABLE) begin
                    if (fall && (INC_SEC != 0)) begin
                        time_next = arith_sat ? MAX_TIME : arith_res;
                    end
                    state_next = ST_IDLE;
                end else begin
                    if (tmr.TICK) begin
                        time_next = arith_res;
                    end
                    if (cur_zero || (tmr.TICK && arith_zero)) begin
                        state_next = ST_EXPIRED;
                    end
                end
            end
            ST_EXPIRED: begin
                state_next = ST_EXPIRED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR || tmr.LOAD) begin
            state_reg   <= ST_IDLE;
            time_reg    <= INIT_TIME;
            en_q_reg    <= 1'b0;
            running_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            en_q_reg    <= tmr.ENABLE;
            running_reg <= (state_next == ST_RUN);
            timeout_reg <= (state_next == ST_EXPIRED);
        end
    end

    assign tmr.MIN_TENS = time_reg.min_tens;
    assign tmr.MIN_ONES = time_reg.min_ones;
    assign tmr.SEC_TENS = time_reg.sec_tens;
    assign tmr.SEC_ONES = time_reg.sec_ones;
    assign tmr.RUNNING  = running_reg;
    assign tmr.TIMEOUT  = timeout_reg;

endmodule

// File: tb/tb_player_timer.sv
// Bench for player_timer: several instances with different INIT/INC settings,
// driven from a vector table plus a long alternating-tick countdown.
module tb_player_timer;

    localparam int NI = 7;
    localparam int P_MIN [NI] = '{0, 1, 99,  0,  0, 0, 10};
    localparam int P_SEC [NI] = '{3, 0, 58, 10,  1, 0,  0};
    localparam int P_INC [NI] = '{0, 5,  5,  2, 10, 0,  0};

    typedef struct {
        int          inst;
        logic        clr;
        logic        load;
        logic        en;
        logic        tick;
        logic [15:0] t;
        logic        to;
        logic        run;
    } vec_t;

    typedef struct {
        int          inst;
        logic [15:0] t;
        logic        to;
        logic        run;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]    clr_v;
    logic [NI-1:0]    tick_v;
    logic [NI-1:0]    en_v;
    logic [NI-1:0]    load_v;
    logic [16*NI-1:0] time_v;
    logic [NI-1:0]    to_v;
    logic [NI-1:0]    run_v;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        player_timer_if bus ();
        assign bus.TICK   = tick_v[gi];
        assign bus.ENABLE = en_v[gi];
        assign bus.LOAD   = load_v[gi];
        assign time_v[gi*16 +: 16] = {bus.MIN_TENS, bus.MIN_ONES, bus.SEC_TENS, bus.SEC_ONES};
        assign to_v[gi]  = bus.TIMEOUT;
        assign run_v[gi] = bus.RUNNING;

        player_timer #(
            .INIT_MIN (P_MIN[gi]),
            .INIT_SEC (P_SEC[gi]),
            .INC_SEC  (P_INC[gi])
        ) u_dut (
            .CLK (clk),
            .CLR (clr_v[gi]),
            .tmr (bus.slave)
        );
    end

    vec_t vecs[$];
    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   step         = 0;

    function automatic vec_t mk(input int inst, input bit clr, input bit load, input bit en,
                                input bit tick, input logic [15:0] t, input bit to, input bit run);
        vec_t v;
        v.inst = inst; v.clr = clr; v.load = load; v.en = en; v.tick = tick;
        v.t = t; v.to = to; v.run = run;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_one();
        exp_t        e;
        logic [15:0] got_t;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard step%0d: got empty queue, want an expectation", step);
            return;
        end
        e     = exp_q.pop_front();
        got_t = time_v[e.inst*16 +: 16];
        $display("[TB] step %0d inst %0d time=%h timeout=%b running=%b", step, e.inst,
                 got_t, to_v[e.inst], run_v[e.inst]);
        tests_run++;
        if (got_t !== e.t) begin
            tests_failed++;
            $display("FAIL time inst%0d step%0d: got %h want %h", e.inst, step, got_t, e.t);
        end
        tests_run++;
        if (to_v[e.inst] !== e.to) begin
            tests_failed++;
            $display("FAIL timeout inst%0d step%0d: got %b want %b", e.inst, step, to_v[e.inst], e.to);
        end
        tests_run++;
        if (run_v[e.inst] !== e.run) begin
            tests_failed++;
            $display("FAIL running inst%0d step%0d: got %b want %b", e.inst, step, run_v[e.inst], e.run);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        clr_v  = '0;
        load_v = '0;
        tick_v = '0;
        clr_v[v.inst]  = v.clr;
        load_v[v.inst] = v.load;
        tick_v[v.inst] = v.tick;
        en_v[v.inst]   = v.en;
        e.inst = v.inst; e.t = v.t; e.to = v.to; e.run = v.run;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_one();
        step++;
    endtask

    initial begin
        int rem;
        bit tk;
        clr_v  = '1;
        en_v   = '0;
        tick_v = '0;
        load_v = '0;
        repeat (2) @(posedge clk);

        // Reset values of every instance.
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0003, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0100, 0, 0));
        vecs.push_back(mk(2, 1, 0, 0, 0, 16'h9958, 0, 0));
        vecs.push_back(mk(3, 1, 0, 0, 0, 16'h0010, 0, 0));
        vecs.push_back(mk(4, 1, 0, 0, 0, 16'h0001, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(6, 1, 0, 0, 0, 16'h1000, 0, 0));
        // 0:03 countdown to expiry, ticks after expiry, LOAD out of EXPIRED.
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0003, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0002, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0001, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0003, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0003, 0, 0));
        // 1:00 minute borrow, +5 on fall, tick honoured on IDLE->RUN, mid-run CLR.
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0100, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h0059, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0104, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h0103, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0100, 0, 0));
        // 99:58 +5 saturates at 99:59.
        vecs.push_back(mk(2, 0, 0, 1, 0, 16'h9958, 0, 1));
        vecs.push_back(mk(2, 0, 0, 0, 0, 16'h9959, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 1, 16'h9958, 0, 1));
        vecs.push_back(mk(2, 0, 0, 0, 0, 16'h9959, 0, 0));
        // Tick coincident with fall is ignored; tick while disabled does nothing.
        vecs.push_back(mk(3, 0, 0, 1, 0, 16'h0010, 0, 1));
        vecs.push_back(mk(3, 0, 0, 0, 1, 16'h0012, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 1, 16'h0012, 0, 0));
        // Expire straight from IDLE, then enable pulses with INC 10 are ignored.
        vecs.push_back(mk(4, 0, 0, 1, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(4, 0, 0, 1, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 16'h0000, 1, 0));
        // Start at 00:00: one RUN cycle, then EXPIRED.
        vecs.push_back(mk(5, 0, 0, 1, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(5, 0, 0, 1, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(5, 0, 0, 1, 1, 16'h0000, 1, 0));
        // 10:00 borrows through MIN_TENS.
        vecs.push_back(mk(6, 0, 0, 1, 1, 16'h0959, 0, 1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Long run on instance 6 with a tick every other cycle against a seconds counter.
        rem = 9 * 60 + 59;
        for (int k = 0; k < 130; k++) begin
            tk = (k % 2) == 1;
            if (tk) rem--;
            apply(mk(6, 0, 0, 1, tk, to_bcd(rem), 0, 1));
        end
        apply(mk(6, 0, 0, 0, 1, to_bcd(rem), 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/player_timer.md
# player_timer

Per-player countdown stage of the chess clock. It sits directly downstream of the turn switch: it consumes one player's enable (`Enable_p1` or `Enable_p2`) and counts that player's remaining time down in BCD mm:ss on a 1 Hz strobe. It adds a Fischer increment when the player's turn ends. It drives `TIMEOUT` back to the switch's `END` input and to the display mux. Two instances are used, one per player.

## Interface
Parameters:
- `INIT_MIN`, 5: initial minutes, 0..99.
- `INIT_SEC`, 0: initial seconds, 0..59.
- `INC_SEC`, 0: Fischer increment in seconds, 0..59. A value of 0 disables the increment.

Ports:
- `CLK`  in  1  system clock; the block's only clock.
- `CLR`  in  1  reset, synchronous and active-high.
- `TICK`  in  1  1 Hz strobe, one `CLK` cycle wide, from the shared prescaler.
- `ENABLE`  in  1  this player's enable from the turn switch.
- `LOAD`  in  1  synchronous reload of the initial time.
- `MIN_TENS`, `MIN_ONES`, `SEC_TENS`, `SEC_ONES`  out  4 each  BCD time remaining.
- `TIMEOUT`  out  1  sticky flag: time has expired.
- `RUNNING`  out  1  high while in state RUN.

## Operation
- States and outputs:
  - IDLE: loaded or paused. `RUNNING`=0, `TIMEOUT`=0.
  - RUN: counting. `RUNNING`=1, `TIMEOUT`=0.
  - EXPIRED: `RUNNING`=0, `TIMEOUT`=1.
- Registered `en_q` is the previous-cycle `ENABLE`.
  - rise = `ENABLE` & ~`en_q`
  - fall = `en_q` & ~`ENABLE`
- Priority per edge: `CLR` > `LOAD` > EXPIRED hold > fall > tick decrement.
- `CLR` or `LOAD`:
  - digits ← `INIT_MIN`:`INIT_SEC` in BCD
  - state ← IDLE, `en_q` ← 0
- IDLE → RUN when `ENABLE`=1.
  - A `TICK` in the same cycle as the transition is honoured, i.e. decrements.
- RUN, `ENABLE`=1, `TICK`=1: decrement by one second.
  - SEC_ONES 0 borrows from SEC_TENS; SEC_TENS 0 wraps to 5 and borrows a minute.
  - MIN_ONES 0 borrows from MIN_TENS; 00:00 never decrements.
- RUN, result 00:00: state ← EXPIRED on the same edge that writes 00:00.
  - `TIMEOUT` and 00:00 become visible together.
- RUN, fall:
  - If `INC_SEC` ≠ 0, add `INC_SEC` seconds with BCD carry into minutes.
  - The sum saturates at 99:59.
  - State ← IDLE.
  - A `TICK` coincident with fall is ignored, because `ENABLE`=0 that cycle.
- `TICK` with `ENABLE`=0 has no effect in any state.
- EXPIRED:
  - Digits frozen at 00:00, `ENABLE`, `TICK` and fall are ignored.
  - No increment is ever applied after expiry.
  - Only `CLR` or `LOAD` leave EXPIRED.
- Starting at 00:00 (`INIT_MIN`=`INIT_SEC`=0): the first RUN cycle goes to EXPIRED without decrementing.
- Digits are always valid BCD: SEC_TENS 0..5, all other digits 0..9.

## Timing
- Reset/`LOAD` values:
  - digits = INIT BCD, `TIMEOUT`=0, `RUNNING`=0
  - visible the cycle after the `CLR`/`LOAD` edge.
- All outputs are registered; no combinational path from input to output.
- Decrement latency: digits update on the `CLK` edge that samples `TICK`=1.
- Increment latency: digits update on the edge that samples `ENABLE`=0 with `en_q`=1, one cycle after `ENABLE` falls.
- `RUNNING` follows `ENABLE` by one cycle.
- `TIMEOUT` to the switch's `END` therefore arrives one cycle after the final decrement. The switch drops its enable on the next edge; EXPIRED already ignores that fall.

## Structure
- Shared package `chess_clock_pkg`:
  - state enum (IDLE, RUN, EXPIRED)
  - 4-bit BCD digit typedef
  - constants `MAX_MIN`=99, `MAX_SEC`=59
  - parameter range checks as elaboration-time assertions
- One sub-module, `bcd_mmss_arith`: combinational.
  - Inputs: mm:ss BCD plus an op select (decrement by 1 / add `INC_SEC`).
  - Outputs: the result, a zero flag and a saturate flag.
- `player_timer` holds the state register, `en_q`, the digit registers and the priority logic.

## Test plan
- INIT 0:03, `ENABLE`=1, three `TICK`s → 00:02, 00:01, 00:00. `TIMEOUT`=1 on the third tick's edge; further ticks leave 00:00.
- INIT 1:00, run one `TICK` → 00:59 (minute borrow, SEC_TENS wraps to 5). Then drop `ENABLE` with `INC_SEC`=5 → 01:04, state IDLE.
- INIT 99:58, `INC_SEC`=5, enable then drop with no tick → saturates at 99:59.
- `TICK` asserted in the same cycle `ENABLE` falls, INIT 0:10, `INC_SEC`=2 → no decrement, result 00:12.
- Mid-run `CLR`, then `LOAD` while EXPIRED: each → INIT digits next cycle, `TIMEOUT`=0, `RUNNING`=0.
- `ENABLE` pulses while EXPIRED with `INC_SEC`=10 → digits stay 00:00 and `TIMEOUT` stays 1.
